sparc_mul_seq: RTL and testbench
================================

// Module: sparc_mul_seq
// PURPOSE
// - Issue sequencer/arbiter for the shared multiplier datapath. Takes EXU and SPU multiply requests and picks one per cycle.
// - Tracks each op through the fixed-latency core pipeline (c1..c5) and generates all datapath controls.
// - Datapath controls: valid, spick, byp_sel/byp_imm, acc_imm, acc_actc2/3/5, acc_reg_enb/rst/shf, x2.
// - Returns per-requester result-valid strobes and resolves SPU accumulator hazards by stall or bypass.
// PARAMETERS
// - MUL_LAT  4  cycles from issue (c1) to mout valid (c5); pipeline tracker depth.
// - MAC_GAP  3  minimum issue spacing between dependent SPU accumulator ops. A spacing of exactly 3 uses immediate bypass.
// PORTS
// - rclk            in   1  clock
// - rst             in   1  reset; asynchronous, active-high
// - exu_req         in   1  EXU multiply request, level, held until exu_ack
// - spu_req         in   1  SPU multiply request, level, held until spu_ack
// - spu_mac         in   1  SPU op accumulates into ACCUM (qualifies spu_req)
// - spu_byp         in   1  SPU op uses ACCUM[63:0] as op2 (qualifies spu_req)
// - spu_x2          in   1  SPU op result doubled (qualifies spu_req)
// - spu_shf_req     in   1  SPU request: shift ACCUM right 64 and read low word
// - spu_clr_req     in   1  SPU request: clear ACCUM
// - exu_ack/spu_ack out  1  one-cycle grant, issue cycle c1
// - spu_cmd_ack     out  1  one-cycle grant for shf/clr
// - exu_res_vld     out  1  mul_data_out holds the EXU result this cycle
// - spu_res_vld     out  1  mul_data_out holds the SPU result or shifted word this cycle
// - valid, spick, byp_sel, byp_imm, acc_imm, acc_actc2, acc_actc3, acc_actc5, acc_reg_enb, acc_reg_rst, acc_reg_shf, x2  out  1  datapath controls
// BEHAVIOUR
// - Reset: all outputs 0; tracker empty; round-robin pointer = EXU favoured. Reset mid-op drops all in-flight ops, no res_vld is issued for them.
// - Issue: at most one mul issue per cycle. valid=1 in c1; spick=1 iff SPU granted; x2=spu_x2 in c1 of SPU ops.
// - Arbitration: an uncontested eligible requester wins. When contested, the winner is the non-last-winner; the pointer flips only on a contested grant.
// - Shf/clr have priority over mul issue when eligible and occupy the cycle (no valid that cycle).
// - Tracker: MUL_LAT-deep shift register of {vld, owner, mac}; advances every cycle.
// - Results: c5 of EXU op -> exu_res_vld=1. c5 of SPU op -> spu_res_vld=1 and acc_reg_enb=1, so ACCUM latches at the c6 edge.
// - MAC controls: acc_actc2=1 when a MAC is in c2; acc_actc3=1 when a MAC is in c3; acc_actc5=1 when a MAC is in c5.
// - acc_imm=1 iff a MAC in c2 coincides with a MAC in c5 (spacing exactly MAC_GAP).
// - Hazard: an SPU MAC or byp op is not eligible while any MAC is in c1..c(MAC_GAP-1) relative to the candidate. It stalls, no ack.
// - byp: byp_sel=1 in c1 of a spu_byp op. byp_imm=1 iff a MAC is in c5 that same cycle; otherwise op2 is taken from acc_reg.
// - Shift: eligible only when no SPU op is in c1..c5. In its grant cycle, acc_reg_shf=1 and acc_reg_enb=1. spu_res_vld=1 the next cycle, when mul_data_out = ACCUM[63:0] after the shift.
// - Clear: eligible under the same condition as shift; acc_reg_rst=1 for one cycle, no res_vld.
// - Simultaneous shf and clr requests: clr wins; shf is retried next cycle.
// - Request dropped before ack: ignored, no state change. EXU ops never touch ACCUM controls.
// STRUCTURE
// - Package sparc_mul_pkg: MUL_LAT and MAC_GAP constants, stage indices C1..C5, tracker entry struct {vld, spu, mac}, owner enum.
// - One sub-module, sparc_mul_rr2: two-way round-robin arbiter with eligibility masks and pointer update on contention.
// - Tracker, hazard logic and control decode live in the top level.
// TESTING
// - exu_req alone at t0 -> exu_ack t0, valid t0, spick=0, exu_res_vld t4, acc_reg_enb never set.
// - exu_req and spu_req both held 4 cycles from reset -> grants EXU, SPU, EXU, SPU; res_vld in the same order 4 cycles later.
// - SPU MAC at t0, next MAC held from t1 -> second ack at t3; acc_imm=acc_actc2=acc_actc5=1 at t4; acc_actc3 at t5.
// - SPU MAC at t0 then spu_byp at t1 -> byp ack at t4 with byp_sel=1 and byp_imm=1.
// - spu_shf_req while a MAC is in flight (t0) -> cmd_ack at t5; acc_reg_shf and acc_reg_enb at t5; spu_res_vld at t6.
// - Two ops in flight, rst pulsed at t2 -> all outputs 0 within the cycle, no res_vld afterwards, and the next exu_req issues normally.

Source files
------------

// File: rtl/sparc_mul_pkg.sv
// Shared constants and types for the multiplier issue sequencer: pipeline depth,
// accumulator dependency spacing, stage numbering and the tracker entry layout.
package sparc_mul_pkg;

    localparam int MUL_LAT = 4;
    localparam int MAC_GAP = 3;

    localparam int C1 = 1;
    localparam int C2 = 2;
    localparam int C3 = 3;
    localparam int C4 = 4;
    localparam int C5 = C1 + MUL_LAT;

    typedef enum logic {
        OWN_EXU = 1'b0,
        OWN_SPU = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
        logic   mac;
    } trk_ent_t;

    localparam trk_ent_t TRK_EMPTY = '{vld: 1'b0, own: OWN_EXU, mac: 1'b0};

    function automatic logic mac_in(trk_ent_t e);
        return e.vld && (e.own == OWN_SPU) && e.mac;
    endfunction

endpackage

// File: rtl/sparc_mul_rr2.sv
// Two-way round-robin arbiter between EXU and SPU. A lone eligible requester always
// wins; on contention the favoured side wins and favour passes to the other side.
module sparc_mul_rr2
    import sparc_mul_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_exu_i,
    input  logic req_spu_i,
    output logic gnt_exu_o,
    output logic gnt_spu_o
);

    owner_e fav_q;
    owner_e fav_d;

    always_comb begin
        gnt_exu_o = 1'b0;
        gnt_spu_o = 1'b0;
        fav_d     = fav_q;
        if (req_exu_i && req_spu_i) begin
            if (fav_q == OWN_EXU) begin
                gnt_exu_o = 1'b1;
                fav_d     = OWN_SPU;
            end else begin
                gnt_spu_o = 1'b1;
                fav_d     = OWN_EXU;
            end
        end else begin
            gnt_exu_o = req_exu_i;
            gnt_spu_o = req_spu_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fav_q <= OWN_EXU;
        else       fav_q <= fav_d;
    end

endmodule

// File: rtl/sparc_mul_seq.sv
// Issue sequencer for the shared multiplier: arbitrates EXU/SPU requests, tracks ops
// through c2..c5, resolves ACCUM hazards and decodes all datapath controls.
module sparc_mul_seq
    import sparc_mul_pkg::*;
(
    input  logic rclk,
    input  logic rst,
    input  logic exu_req,
    input  logic spu_req,
    input  logic spu_mac,
    input  logic spu_byp,
    input  logic spu_x2,
    input  logic spu_shf_req,
    input  logic spu_clr_req,
    output logic exu_ack,
    output logic spu_ack,
    output logic spu_cmd_ack,
    output logic exu_res_vld,
    output logic spu_res_vld,
    output logic valid,
    output logic spick,
    output logic byp_sel,
    output logic byp_imm,
    output logic acc_imm,
    output logic acc_actc2,
    output logic acc_actc3,
    output logic acc_actc5,
    output logic acc_reg_enb,
    output logic acc_reg_rst,
    output logic acc_reg_shf,
    output logic x2
);

    trk_ent_t [C5:C2] trk_q;
    trk_ent_t         iss_d;
    logic             shf_pend_q;

    logic mac_blk, byp_blk, spu_busy;
    logic clr_gnt, shf_gnt, cmd_gnt;
    logic exu_elig, spu_elig, gnt_exu, gnt_spu;

    // A dependent MAC may issue once the older MAC reaches c(MAC_GAP+1) and picks it
    // up through acc_imm; a byp op reads op2 in c1, so it must wait for the c5 bypass.
    always_comb begin
        mac_blk  = 1'b0;
        byp_blk  = 1'b0;
        spu_busy = 1'b0;
        for (int s = C2; s <= C5; s++) begin
            if (mac_in(trk_q[3'(s)])) begin
                if (s < C1 + MAC_GAP) mac_blk = 1'b1;
                if (s < C5)           byp_blk = 1'b1;
            end
            if (trk_q[3'(s)].vld && trk_q[3'(s)].own == OWN_SPU) spu_busy = 1'b1;
        end
    end

    assign clr_gnt  = !rst && spu_clr_req && !spu_busy;
    assign shf_gnt  = !rst && spu_shf_req && !spu_busy && !spu_clr_req;
    assign cmd_gnt  = clr_gnt || shf_gnt;
    assign exu_elig = !rst && exu_req && !cmd_gnt;
    assign spu_elig = !rst && spu_req && !cmd_gnt
                      && !(spu_mac && mac_blk) && !(spu_byp && byp_blk);

    sparc_mul_rr2 u_rr2 (
        .clk_i     (rclk),
        .rst_i     (rst),
        .req_exu_i (exu_elig),
        .req_spu_i (spu_elig),
        .gnt_exu_o (gnt_exu),
        .gnt_spu_o (gnt_spu)
    );

    always_comb begin
        iss_d = TRK_EMPTY;
        if (gnt_exu)      iss_d = '{vld: 1'b1, own: OWN_EXU, mac: 1'b0};
        else if (gnt_spu) iss_d = '{vld: 1'b1, own: OWN_SPU, mac: spu_mac};
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            trk_q      <= '0;
            shf_pend_q <= 1'b0;
        end else begin
            trk_q      <= {trk_q[C4:C2], iss_d};
            shf_pend_q <= shf_gnt;
        end
    end

    assign exu_ack     = gnt_exu;
    assign spu_ack     = gnt_spu;
    assign spu_cmd_ack = cmd_gnt;
    assign valid       = gnt_exu || gnt_spu;
    assign spick       = gnt_spu;
    assign x2          = gnt_spu && spu_x2;
    assign byp_sel     = gnt_spu && spu_byp;
    assign byp_imm     = gnt_spu && spu_byp && mac_in(trk_q[C5]);

    assign acc_actc2   = mac_in(trk_q[C2]);
    assign acc_actc3   = mac_in(trk_q[C3]);
    assign acc_actc5   = mac_in(trk_q[C5]);
    assign acc_imm     = acc_actc2 && acc_actc5;

    assign exu_res_vld = trk_q[C5].vld && trk_q[C5].own == OWN_EXU;
    assign spu_res_vld = (trk_q[C5].vld && trk_q[C5].own == OWN_SPU) || shf_pend_q;
    assign acc_reg_enb = (trk_q[C5].vld && trk_q[C5].own == OWN_SPU) || shf_gnt;
    assign acc_reg_shf = shf_gnt;
    assign acc_reg_rst = clr_gnt;

endmodule

// File: tb/tb_sparc_mul_seq.sv
// Bench for sparc_mul_seq: directed scenarios plus randomized traffic, checked every
// cycle against an issue-history reference model.
module tb_sparc_mul_seq;

    localparam int NC = 4096;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    logic exu_req = 1'b0, spu_req = 1'b0, spu_mac = 1'b0, spu_byp = 1'b0, spu_x2 = 1'b0;
    logic spu_shf_req = 1'b0, spu_clr_req = 1'b0;
    logic exu_ack, spu_ack, spu_cmd_ack, exu_res_vld, spu_res_vld, valid, spick;
    logic byp_sel, byp_imm, acc_imm, acc_actc2, acc_actc3, acc_actc5;
    logic acc_reg_enb, acc_reg_rst, acc_reg_shf, x2;

    sparc_mul_seq dut (
        .rclk(rclk), .rst(rst), .exu_req(exu_req), .spu_req(spu_req), .spu_mac(spu_mac),
        .spu_byp(spu_byp), .spu_x2(spu_x2), .spu_shf_req(spu_shf_req),
        .spu_clr_req(spu_clr_req), .exu_ack(exu_ack), .spu_ack(spu_ack),
        .spu_cmd_ack(spu_cmd_ack), .exu_res_vld(exu_res_vld), .spu_res_vld(spu_res_vld),
        .valid(valid), .spick(spick), .byp_sel(byp_sel), .byp_imm(byp_imm),
        .acc_imm(acc_imm), .acc_actc2(acc_actc2), .acc_actc3(acc_actc3),
        .acc_actc5(acc_actc5), .acc_reg_enb(acc_reg_enb), .acc_reg_rst(acc_reg_rst),
        .acc_reg_shf(acc_reg_shf), .x2(x2)
    );

    always #5 rclk = ~rclk;

    int n_chk = 0;
    int n_fail = 0;

    // Issue history: h_own 0 = none, 1 = EXU, 2 = SPU; indexed by cycle number.
    int cyc = 0;
    int rst_cyc = -1;
    int fav = 0;
    int h_own [NC];
    bit h_mac [NC];
    bit h_shf [NC];

    logic r_exu = 1'b0, r_spu = 1'b0, r_mac = 1'b0, r_byp = 1'b0, r_x2 = 1'b0;
    logic r_shf = 1'b0, r_clr = 1'b0;
    bit last_ge, last_gs, last_clr, last_shf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int own_ago(int d);
        int i = cyc - d;
        if (i <= rst_cyc || i < 0) return 0;
        return h_own[i];
    endfunction

    function automatic bit mac_ago(int d);
        return own_ago(d) == 2 && h_mac[cyc - d];
    endfunction

    function automatic bit shf_ago(int d);
        int i = cyc - d;
        if (i <= rst_cyc || i < 0) return 1'b0;
        return h_shf[i];
    endfunction

    task automatic eval_cycle();
        bit busy, mblk, bblk, e_clr, e_shf, el_e, el_s, ge, gs;
        busy = 1'b0;
        for (int d = 1; d <= 4; d++) if (own_ago(d) == 2) busy = 1'b1;
        mblk  = mac_ago(1) || mac_ago(2);
        bblk  = mac_ago(1) || mac_ago(2) || mac_ago(3);
        e_clr = spu_clr_req && !busy;
        e_shf = spu_shf_req && !busy && !spu_clr_req;
        ge = 1'b0;
        gs = 1'b0;
        if (!(e_clr || e_shf)) begin
            el_e = exu_req;
            el_s = spu_req && !(spu_mac && mblk) && !(spu_byp && bblk);
            if (el_e && el_s) begin
                if (fav == 0) begin ge = 1'b1; fav = 1; end
                else          begin gs = 1'b1; fav = 0; end
            end else begin
                ge = el_e;
                gs = el_s;
            end
        end
        chk("exu_ack", exu_ack, ge);
        chk("spu_ack", spu_ack, gs);
        chk("cmd_ack", spu_cmd_ack, e_clr || e_shf);
        chk("valid", valid, ge || gs);
        chk("spick", spick, gs);
        chk("x2", x2, gs && spu_x2);
        chk("byp_sel", byp_sel, gs && spu_byp);
        chk("byp_imm", byp_imm, gs && spu_byp && mac_ago(4));
        chk("actc2", acc_actc2, mac_ago(1));
        chk("actc3", acc_actc3, mac_ago(2));
        chk("actc5", acc_actc5, mac_ago(4));
        chk("acc_imm", acc_imm, mac_ago(1) && mac_ago(4));
        chk("exu_res_vld", exu_res_vld, own_ago(4) == 1);
        chk("spu_res_vld", spu_res_vld, own_ago(4) == 2 || shf_ago(1));
        chk("acc_reg_enb", acc_reg_enb, own_ago(4) == 2 || e_shf);
        chk("acc_reg_shf", acc_reg_shf, e_shf);
        chk("acc_reg_rst", acc_reg_rst, e_clr);
        h_own[cyc] = ge ? 1 : (gs ? 2 : 0);
        h_mac[cyc] = gs && spu_mac;
        h_shf[cyc] = e_shf;
        last_ge  = ge;
        last_gs  = gs;
        last_clr = e_clr;
        last_shf = e_shf;
        cyc++;
    endtask

    task automatic drive();
        exu_req     = r_exu;
        spu_req     = r_spu;
        spu_mac     = r_mac;
        spu_byp     = r_byp;
        spu_x2      = r_x2;
        spu_shf_req = r_shf;
        spu_clr_req = r_clr;
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge rclk);
        eval_cycle();
        if (last_ge)  r_exu = 1'b0;
        if (last_gs)  r_spu = 1'b0;
        if (last_clr) r_clr = 1'b0;
        if (last_shf) r_shf = 1'b0;
    endtask

    task automatic reset_cycle();
        @(posedge rclk);
        #1;
        rst = 1'b1;
        drive();
        @(negedge rclk);
        chk("rst_outs", {exu_ack, spu_ack, spu_cmd_ack, exu_res_vld, spu_res_vld, valid,
                         spick, byp_sel, byp_imm, acc_imm, acc_actc2, acc_actc3, acc_actc5,
                         acc_reg_enb, acc_reg_rst, acc_reg_shf, x2}, 32'd0);
        rst_cyc = cyc;
        fav = 0;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic spu_op(input logic mac, input logic byp, input logic dbl);
        r_spu = 1'b1;
        r_mac = mac;
        r_byp = byp;
        r_x2  = dbl;
    endtask

    task automatic rand_refresh();
        if (last_ge || $urandom_range(15) == 0) r_exu = 1'($urandom_range(1));
        if (last_gs || $urandom_range(15) == 0) begin
            r_spu = 1'($urandom_range(1));
            r_mac = 1'($urandom_range(1));
            r_byp = ($urandom_range(2) == 0);
            r_x2  = 1'($urandom_range(1));
        end
        if ($urandom_range(19) == 0) r_clr = 1'b1;
        if ($urandom_range(14) == 0) r_shf = 1'b1;
    endtask

    initial begin
        // EXU alone
        reset_cycle();
        r_exu = 1'b1;
        run(7);

        // contested EXU/SPU held for four cycles
        reset_cycle();
        for (int k = 0; k < 4; k++) begin
            r_exu = 1'b1;
            spu_op(1'b0, 1'b0, k[0]);
            step();
        end
        run(6);

        // dependent MAC pair
        reset_cycle();
        spu_op(1'b1, 1'b0, 1'b0);
        step();
        spu_op(1'b1, 1'b0, 1'b1);
        run(9);

        // MAC then bypass op
        reset_cycle();
        spu_op(1'b1, 1'b0, 1'b0);
        step();
        spu_op(1'b0, 1'b1, 1'b0);
        run(8);

        // shift while a MAC is in flight
        reset_cycle();
        spu_op(1'b1, 1'b0, 1'b0);
        step();
        r_shf = 1'b1;
        run(8);

        // simultaneous clear and shift
        reset_cycle();
        r_clr = 1'b1;
        r_shf = 1'b1;
        run(4);

        // reset with two ops in flight
        reset_cycle();
        r_exu = 1'b1;
        step();
        spu_op(1'b0, 1'b0, 1'b0);
        step();
        r_exu = 1'b1;
        reset_cycle();
        run(7);

        // randomized traffic with occasional resets
        reset_cycle();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(199) == 0) reset_cycle();
            else step();
            rand_refresh();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
